ui_input_conditioner: RTL

- Front-end stage that sits directly upstream of the project FSM in the `tt_um_fsm` top.
- Takes the raw dedicated inputs (`ui_in`) and produces clean, synchronized, debounced per-bit levels, plus one-cycle rise and fall pulses.
- The FSM consumes these outputs instead of raw pins, so it never sees metastable or bouncing inputs.
- Every bit is conditioned independently.

---
 rtl/ui_input_conditioner.sv | 71 +++++++
 1 files changed

// File: rtl/ui_input_conditioner.sv
// Input front end for the project FSM: two-flop synchronizer, per-bit debounce
// and one-cycle rise/fall pulses on each debounced level change.
module ui_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] update;

    // With ena low, update stays 0 and counters hold, so pulses clear naturally.
    always_comb begin
        cnt_nxt = cnt;
        update  = '0;
        if (ena) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == level_out[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_TC) begin
                    update[i]  = 1'b1;
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            busy = busy | (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            level_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= in_raw;
            sync2      <= sync1;
            level_out  <= level_out ^ update;
            rise_pulse <= update & sync2;
            fall_pulse <= update & ~sync2;
            cnt        <= cnt_nxt;
        end
    end

endmodule
